// File: rtl/address_byte_loader_pkg.sv
// Shared widths and state encoding for the address byte loader.
// The loader assembles a 16-bit address from two little-endian bytes
// (or increments the last committed address) and strobes it into a
// downstream 16-bit register.
package address_byte_loader_pkg;

    // Width of the incoming byte bus.
    localparam int DATA_W = 8;

    // Width of the assembled address.
    localparam int ADDR_W = 16;

    // FSM encoding. 2'b11 is unused and decodes back to IDLE.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT_HI = 2'b01,
        COMMIT  = 2'b10
    } state_e;

    // True when the state is an encoding the FSM can legally occupy.
    function automatic logic state_is_legal(input logic [1:0] st);
        return (st == IDLE) || (st == WAIT_HI) || (st == COMMIT);
    endfunction

endpackage

// File: rtl/address_byte_loader_incrementer_16b.sv
// 16-bit +1 unit. The carry out is the wrap indication: it is set only
// when the input is all ones and the sum rolls over to zero.
module incrementer_16b
    import address_byte_loader_pkg::*;
(
    input  logic [ADDR_W-1:0] addr_in,
    output logic [ADDR_W-1:0] sum_out,
    output logic              carry_out
);

    // One extra bit on the left catches the rollover.
    logic [ADDR_W:0] full_sum;

    // Widened add so the carry falls out of the top bit.
    always_comb begin
        full_sum  = {1'b0, addr_in} + {{ADDR_W{1'b0}}, 1'b1};
        sum_out   = full_sum[ADDR_W-1:0];
        carry_out = full_sum[ADDR_W];
    end

endmodule

// File: rtl/address_byte_loader.sv
// Address byte loader.
// Two bytes on the 8-bit bus (low first, then high) are assembled into a
// 16-bit address; alternatively an inc_req bumps the last committed
// address by one. Either way the FSM passes through COMMIT for exactly one
// cycle, during which addr_out carries the new value and addr_load pulses
// so the downstream register captures it. addr_out is itself registered
// and holds its last committed value at all other times.
module address_byte_loader
    import address_byte_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_ADDR = 16'h0000
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              inc_req,
    input  logic              abort,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_load,
    output logic              wrap,
    output logic              busy
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [ADDR_W-1:0] addr_q;
    logic              wrap_q;

    // Value and wrap flag to be presented during the coming COMMIT cycle.
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_wrap;
    logic              commit_next;

    // Incrementer results for the current committed address.
    logic [ADDR_W-1:0] inc_sum;
    logic              inc_carry;

    // Handshake qualifier: a byte is actually taken this cycle.
    logic              xfer;

    // ------------------------------------------------------------------
    // +1 / wrap unit
    // ------------------------------------------------------------------
    incrementer_16b u_inc (
        .addr_in   (addr_q),
        .sum_out   (inc_sum),
        .carry_out (inc_carry)
    );

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    // byte_ready is a state decode, except that an abort in WAIT_HI
    // withdraws it so the colliding byte is visibly refused.
    always_comb begin
        byte_ready = 1'b0;
        unique case (state_q)
            IDLE:    byte_ready = 1'b1;
            WAIT_HI: byte_ready = ~abort;
            default: byte_ready = 1'b0;
        endcase
        xfer      = byte_valid & byte_ready;
        addr_out  = addr_q;
        addr_load = (state_q == COMMIT);
        wrap      = wrap_q;
        busy      = (state_q != IDLE);
    end

    // ------------------------------------------------------------------
    // Next-state and pending-value logic
    // ------------------------------------------------------------------
    // Next state, byte latches and the value to commit; defaults hold.
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        pend_addr   = addr_q;
        pend_wrap   = 1'b0;
        commit_next = 1'b0;

        case (state_q)
            IDLE: begin
                // A byte beats a simultaneous inc_req; the request is
                // dropped rather than remembered.
                if (xfer) begin
                    lo_d    = byte_in;
                    state_d = WAIT_HI;
                end else if (inc_req) begin
                    pend_addr   = inc_sum;
                    pend_wrap   = inc_carry;
                    commit_next = 1'b1;
                    state_d     = COMMIT;
                end
            end

            WAIT_HI: begin
                // abort wins over a byte; inc_req is not looked at here.
                if (abort) begin
                    lo_d    = '0;
                    state_d = IDLE;
                end else if (xfer) begin
                    hi_d        = byte_in;
                    pend_addr   = {hi_d, lo_q};
                    pend_wrap   = 1'b0;
                    commit_next = 1'b1;
                    state_d     = COMMIT;
                end
            end

            COMMIT: begin
                state_d = IDLE;
            end

            default: begin
                // Unused encoding: fall back to IDLE.
                state_d = IDLE;
            end
        endcase

        if (!state_is_legal(state_q)) begin
            state_d = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // State register with asynchronous clear.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Byte latches; cleared so a partial address never survives a clear.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    // Committed address: updated on the edge entering COMMIT, then held.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            addr_q <= RESET_ADDR;
        end else if (commit_next) begin
            addr_q <= pend_addr;
        end
    end

    // Wrap flag: only ever set for the single COMMIT cycle it belongs to.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= commit_next & pend_wrap;
        end
    end

endmodule

// File: tb/tb_address_byte_loader.sv
// Scoreboard bench for address_byte_loader: stimulus pushes expected
// strobes, a monitor pops and compares whenever addr_load is seen.
module tb_address_byte_loader;

    logic        clock = 1'b0;
    logic        clear;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        inc_req;
    logic        abort;
    logic [15:0] addr_out;
    logic        addr_load;
    logic        wrap;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic        wrap;
    } exp_t;

    exp_t exp_q[$];

    address_byte_loader #(.RESET_ADDR(16'h8000)) dut (
        .clock      (clock),
        .clear      (clear),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .inc_req    (inc_req),
        .abort      (abort),
        .addr_out   (addr_out),
        .addr_load  (addr_load),
        .wrap       (wrap),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic expect_strobe(input logic [15:0] a, input logic w);
        exp_t e;
        e.addr = a;
        e.wrap = w;
        exp_q.push_back(e);
    endtask

    // Advance one clock; inputs change and direct checks happen 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every strobe must match the oldest expected one.
    always @(negedge clock) begin
        if (!clear) begin
            if (addr_load) begin
                exp_t e;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe actual addr=%h wrap=%b required none", addr_out, wrap);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (addr_out !== e.addr || wrap !== e.wrap) begin
                        errors++;
                        $display("FAIL strobe actual addr=%h wrap=%b required addr=%h wrap=%b",
                                 addr_out, wrap, e.addr, e.wrap);
                    end else begin
                        $display("ok   strobe addr=%h wrap=%b", addr_out, wrap);
                    end
                end
            end else if (wrap !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL wrap_without_load actual=%b required=0", wrap);
            end
        end
    end

    initial begin
        clear      = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        inc_req    = 1'b0;
        abort      = 1'b0;
        step();
        step();

        // Reset state
        check("rst_addr_out",  addr_out,          16'h8000);
        check("rst_addr_load", {15'd0, addr_load}, 16'd0);
        check("rst_wrap",      {15'd0, wrap},      16'd0);
        check("rst_busy",      {15'd0, busy},      16'd0);

        clear = 1'b0;
        step();
        check("ready_after_clear", {15'd0, byte_ready}, 16'd1);

        // 0x34 then 0x12 -> 0x1234, strobe one cycle after the high byte
        byte_valid = 1'b1; byte_in = 8'h34;
        step();
        check("busy_wait_hi", {15'd0, busy}, 16'd1);
        byte_in = 8'h12;
        expect_strobe(16'h1234, 1'b0);
        step();
        byte_valid = 1'b0;
        check("latency_bytes", {15'd0, addr_load}, 16'd1);
        check("commit_not_ready", {15'd0, byte_ready}, 16'd0);
        step();
        check("hold_after_commit", addr_out, 16'h1234);

        // Three increments, two cycles apart
        for (int i = 0; i < 3; i++) begin
            inc_req = 1'b1;
            expect_strobe(16'h1235 + 16'(i), 1'b0);
            step();
            inc_req = 1'b0;
            check("latency_inc", {15'd0, addr_load}, 16'd1);
            step();
        end

        // 0xFFFF then increment -> 0x0000 with wrap, then 0x0001 without
        byte_valid = 1'b1; byte_in = 8'hFF;
        step();
        expect_strobe(16'hFFFF, 1'b0);
        step();
        byte_valid = 1'b0;
        step();
        inc_req = 1'b1;
        expect_strobe(16'h0000, 1'b1);
        step();
        inc_req = 1'b0;
        step();
        inc_req = 1'b1;
        expect_strobe(16'h0001, 1'b0);
        step();
        inc_req = 1'b0;
        step();

        // 0xAA then abort colliding with 0xBB: nothing committed
        byte_valid = 1'b1; byte_in = 8'hAA;
        step();
        byte_in = 8'hBB; abort = 1'b1;
        #1;
        check("abort_not_ready", {15'd0, byte_ready}, 16'd0);
        step();
        abort = 1'b0; byte_valid = 1'b0;
        check("abort_idle", {15'd0, busy}, 16'd0);
        check("abort_addr_held", addr_out, 16'h0001);
        step();

        // Fresh pair after abort; low byte must come from this pair
        byte_valid = 1'b1; byte_in = 8'hCD;
        step();
        byte_in = 8'hEF;
        expect_strobe(16'hEFCD, 1'b0);
        step();
        byte_valid = 1'b0;
        step();

        // Byte and inc_req together in IDLE: byte wins, no inc strobe
        byte_valid = 1'b1; byte_in = 8'h56; inc_req = 1'b1;
        step();
        inc_req = 1'b0; byte_in = 8'h78;
        expect_strobe(16'h7856, 1'b0);
        step();
        byte_valid = 1'b0;
        step();

        // inc_req in WAIT_HI ignored; abort in IDLE has no effect
        abort = 1'b1; byte_valid = 1'b1; byte_in = 8'h11;
        step();
        abort = 1'b0; byte_valid = 1'b0; inc_req = 1'b1;
        step();
        inc_req = 1'b0; byte_valid = 1'b1; byte_in = 8'h22;
        expect_strobe(16'h2211, 1'b0);
        step();
        byte_valid = 1'b0;
        step();

        // clear in WAIT_HI: immediate reset value, no strobe afterwards
        byte_valid = 1'b1; byte_in = 8'h99;
        step();
        byte_valid = 1'b0;
        clear = 1'b1;
        #1;
        check("clear_async_addr", addr_out, 16'h8000);
        check("clear_async_busy", {15'd0, busy}, 16'd0);
        step();
        clear = 1'b0;
        #1;
        check("ready_after_clear2", {15'd0, byte_ready}, 16'd1);
        for (int i = 0; i < 4; i++) step();
        check("clear_addr_held", addr_out, 16'h8000);

        // Every expected strobe must have been seen
        check("pending_strobes", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/address_byte_loader.md
ADDRESS_BYTE_LOADER -- requirements
Module: address_byte_loader

Interface
REQ-001 Parameter RESET_ADDR, default 16'h0000, value of addr_out after reset.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-high.
REQ-004 byte_in  input  8  byte from the 8-bit data bus.
REQ-005 byte_valid  input  1  byte_in holds a valid byte.
REQ-006 byte_ready  output  1  block accepts byte_in this cycle; a transfer occurs when byte_valid and byte_ready are both 1 at a rising edge.
REQ-007 inc_req  input  1  request for addr_out + 1.
REQ-008 abort  input  1  discard a partially assembled address.
REQ-009 addr_out  output  16  assembled address; drives d of the downstream 16-bit register.
REQ-010 addr_load  output  1  one-cycle strobe; drives clock_enable of the downstream 16-bit register.
REQ-011 wrap  output  1  valid with addr_load; 1 when an increment wrapped from 16'hFFFF to 16'h0000.
REQ-012 busy  output  1  1 whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT_HI and COMMIT; all outputs SHALL be registered or decoded from the state only.
REQ-014 IDLE: byte_ready SHALL be 1; an accepted byte SHALL be latched as the low byte, and the FSM SHALL move to WAIT_HI.
REQ-015 IDLE with inc_req=1 and no byte transfer: the pending value SHALL be addr_out+1, modulo 2^16; wrap SHALL be set iff addr_out==16'hFFFF; the FSM SHALL move to COMMIT.
REQ-016 IDLE with a byte transfer and inc_req in the same cycle: the byte SHALL win, and inc_req SHALL be dropped, not queued.
REQ-017 WAIT_HI: byte_ready SHALL be 1; an accepted byte SHALL be latched as the high byte; the pending value SHALL be {high,low} with wrap=0; the FSM SHALL move to COMMIT.
REQ-018 WAIT_HI with abort=1: the FSM SHALL return to IDLE, the low byte SHALL be discarded, and addr_load SHALL not fire; abort SHALL take priority over a simultaneous byte transfer, and that byte SHALL not be accepted (byte_ready=0 when abort=1).
REQ-019 WAIT_HI: inc_req SHALL be ignored.
REQ-020 abort in IDLE or COMMIT SHALL have no effect.
REQ-021 COMMIT: byte_ready SHALL be 0; addr_out SHALL equal the pending value and addr_load SHALL be 1 for exactly this one cycle; next state SHALL be IDLE unconditionally.
REQ-022 Latency: a high byte accepted at edge N, or an inc_req sampled at edge N, SHALL give addr_load=1 in the cycle after edge N.
REQ-023 addr_out SHALL hold its last committed value between strobes and while in WAIT_HI.
REQ-024 Address bytes SHALL be little-endian: first byte is bits 7:0, second byte is bits 15:8.
REQ-025 wrap SHALL be 0 whenever addr_load is 0.

Reset
REQ-026 clear=1 SHALL immediately force: state IDLE; addr_out=RESET_ADDR; addr_load=0; wrap=0; busy=0; low and high byte latches=0.
REQ-027 clear asserted in WAIT_HI or COMMIT SHALL discard the partial or pending address, and no addr_load SHALL follow the release of clear.
REQ-028 After clear deasserts, byte_ready SHALL be 1 in the first cycle.

Structure
REQ-029 A shared package SHALL hold DATA_W=8, ADDR_W=16 and the state encoding constants: IDLE=2'b00, WAIT_HI=2'b01, COMMIT=2'b10.
REQ-030 The +1 and wrap logic SHALL be one sub-module, incrementer_16b (16-bit in; 16-bit sum and carry out).
REQ-031 The unused state encoding 2'b11 SHALL recover to IDLE.

Verification
REQ-032 Reset release, then bytes 8'h34 then 8'h12 on consecutive cycles -> one addr_load pulse with addr_out=16'h1234 and wrap=0, one cycle after the second byte.
REQ-033 After 16'h1234 is committed, inc_req pulsed 3 times, each 2 cycles apart -> three strobes with 16'h1235, 16'h1236 and 16'h1237.
REQ-034 Load 8'hFF, 8'hFF, then inc_req -> strobe with addr_out=16'h0000 and wrap=1; the next strobe has wrap=0.
REQ-035 Byte 8'hAA, then abort with byte_valid=1 and byte_in=8'hBB -> no addr_load, byte_ready=0 in that cycle, state IDLE, addr_out unchanged.
REQ-036 byte_valid and inc_req together in IDLE with 8'h56, then 8'h78 -> a single strobe with 16'h7856, and no increment strobe.
REQ-037 clear pulsed in WAIT_HI, with RESET_ADDR=16'h8000 -> addr_out=16'h8000 immediately, and no strobe afterwards.
